decoder_2to4: RTL and testbench
===============================

// Module: decoder_2to4
// PURPOSE
// - Registered 2-to-4 one-hot decoder with selectable output polarity.
// - Used by the DMA priority block to turn a 2-bit channel select (request-register bits [1:0]) into a 4-bit per-channel strobe.
// - Also used for DACK-style acknowledge generation, where the strobe may be active-high or active-low.
// - Provides a same-cycle combinational decode and a one-cycle registered copy.
// PARAMETERS
// - SEL_W     2   select width; output width OUT_W = 2**SEL_W (only 2 supported/verified)
// - RST_IDLE  1   1: registered raw one-hot clears to all-zero on reset (only value supported)
// PORTS
// - clk       in   1  rising-edge clock; single clock domain
// - RESET     in   1  reset, asynchronous, active-low
// - sel       in   2  channel select (00=ch0 .. 11=ch3)
// - en        in   1  decode enable; 0 = no channel selected
// - pol_high  in   1  output sense: 1 = active-high, 0 = active-low
// - dec_c     out  4  combinational decode of sel/en, polarity applied
// - dec_q     out  4  registered decode, polarity applied
// - vld_q     out  1  registered en (1 = dec_q holds a selected channel)
// BEHAVIOUR
// Raw one-hot
// - raw_c = en ? (4'b0001 << sel) : 4'b0000.
// - Exactly one bit is set when en=1; none when en=0.
// Combinational output
// - dec_c = pol_high ? raw_c : ~raw_c.
// - Zero latency; follows sel, en and pol_high immediately.
// Registered path
// - raw_q <= raw_c on each rising clk.
// - vld_q <= en on each rising clk.
// - Latency is 1 cycle; no hold or stall, so the register updates every cycle.
// - dec_q = pol_high ? raw_q : ~raw_q.
// - Polarity is applied after the register, so a pol_high change takes effect on dec_q in the same cycle.
// Reset
// - When RESET=0 (asynchronous assert): raw_q=4'b0000, vld_q=0.
// - Resulting dec_q: 4'b0000 if pol_high=1, 4'b1111 if pol_high=0 (all channels deasserted).
// - Reset takes priority over the clock edge.
// - Release is synchronous-safe: the first capture is on the first rising clk after RESET goes to 1.
// - Reset mid-operation clears dec_q/vld_q immediately; dec_c is unaffected by reset.
// Boundaries
// - sel=11 selects bit 3. No wrap and no illegal codes: all 4 sel values are valid.
// - X/Z on sel while en=0 must not propagate: output is the all-deasserted pattern.
// Invariants
// - When vld_q=1, popcount(raw_q)=1.
// - When vld_q=0, raw_q=0.
// STRUCTURE
// - Shared package dma_pkg: DMA_NCH=4, DMA_CH_W=2, typedef ch_sel_t [1:0], typedef ch_vec_t [3:0].
// - No sub-module: one combinational decode function (dec2to4) plus one register and a polarity XOR stage.
// - The dec2to4 function lives in dma_pkg so the priority block can reuse it.
// TESTING
// - Reset: RESET=0, pol_high=1 -> dec_q=0000, vld_q=0. Set pol_high=0 -> dec_q=1111 with no clock edge.
// - Sweep, pol_high=1, en=1, sel=00,01,10,11:
//   - dec_c = 0001, 0010, 0100, 1000 in the same cycle.
//   - dec_q shows the same sequence one cycle later, with vld_q=1.
// - Active-low, pol_high=0, en=1, sel=10 -> dec_c=1011, then dec_q=1011 after 1 clk.
// - Disable: en=0, sel=11 -> dec_c=0000 (pol 1) / 1111 (pol 0); next cycle vld_q=0 and dec_q deasserted.
// - Async reset mid-run: dec_q=1000, RESET pulsed low between clk edges -> dec_q=0000 at once.
//   - After release with sel=01, en=1: dec_q=0010 on the next edge.
// - Polarity flip: registered sel=01 held (dec_q=0010), toggle pol_high to 0 -> dec_q=1101 without a clock edge.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA types and the channel-select decode used by the decoder and the priority block.
package dma_pkg;

  localparam int DMA_NCH  = 4;
  localparam int DMA_CH_W = 2;

  typedef logic [DMA_CH_W-1:0] ch_sel_t;
  typedef logic [DMA_NCH-1:0]  ch_vec_t;

  // Only the enabled branch indexes by sel, so an unknown sel under en=0 cannot leak out.
  function automatic ch_vec_t dec2to4(input ch_sel_t sel, input logic en);
    ch_vec_t v;
    v = '0;
    if (en) begin
      v[sel] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 one-hot channel decoder with output polarity applied after the register.
module decoder_2to4
  import dma_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int RST_IDLE = 1
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  input  logic                  pol_high,
  output logic [(2**SEL_W)-1:0] dec_c,
  output logic [(2**SEL_W)-1:0] dec_q,
  output logic                  vld_q
);

  localparam int OUT_W = 2 ** SEL_W;

  if (SEL_W != DMA_CH_W || OUT_W != DMA_NCH || RST_IDLE != 1) begin : g_param_check
    $error("decoder_2to4: only SEL_W=2 and RST_IDLE=1 are supported");
  end

  function automatic ch_vec_t apply_pol(input ch_vec_t raw, input logic high);
    return high ? raw : ~raw;
  endfunction

  ch_vec_t raw_p0;
  ch_vec_t raw_p1;
  logic    vld_p1;

  // Stage p0: same-cycle decode
  always_comb begin
    raw_p0 = dec2to4(ch_sel_t'(sel), en);
  end

  assign dec_c = apply_pol(raw_p0, pol_high);

  // Stage p1: registered raw one-hot and valid
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      raw_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      raw_p1 <= raw_p0;
      vld_p1 <= en;
    end
  end

  assign dec_q = apply_pol(raw_p1, pol_high);
  assign vld_q = vld_p1;

endmodule

// File: tb/tb_decoder_2to4.sv
// Directed bench for decoder_2to4: reset, sweep, polarity, disable and mid-run async reset.
module tb_decoder_2to4;

  logic       clk = 1'b0;
  logic       RESET;
  logic [1:0] sel;
  logic       en;
  logic       pol_high;
  logic [3:0] dec_c;
  logic [3:0] dec_q;
  logic       vld_q;

  int checks = 0;
  int errors = 0;

  decoder_2to4 dut (
    .clk      (clk),
    .RESET    (RESET),
    .sel      (sel),
    .en       (en),
    .pol_high (pol_high),
    .dec_c    (dec_c),
    .dec_q    (dec_q),
    .vld_q    (vld_q)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    RESET = 1'b0; pol_high = 1'b1; en = 1'b0; sel = 2'b00;
    #1;
    checks++;
    if (dec_q !== 4'b0000) begin errors++; $display("FAIL reset_dec_q_pol1: got %b want 0000", dec_q); end
    checks++;
    if (vld_q !== 1'b0) begin errors++; $display("FAIL reset_vld_q: got %b want 0", vld_q); end
    pol_high = 1'b0;
    #1;
    checks++;
    if (dec_q !== 4'b1111) begin errors++; $display("FAIL reset_dec_q_pol0: got %b want 1111", dec_q); end
    // Reset must hold the register across clock edges while dec_c still decodes.
    pol_high = 1'b1; en = 1'b1; sel = 2'b10;
    @(posedge clk); #1;
    checks++;
    if (dec_c !== 4'b0100) begin errors++; $display("FAIL reset_dec_c_live: got %b want 0100", dec_c); end
    checks++;
    if (dec_q !== 4'b0000 || vld_q !== 1'b0) begin
      errors++; $display("FAIL reset_priority: got dec_q=%b vld_q=%b want 0000/0", dec_q, vld_q);
    end
    @(negedge clk);
    RESET = 1'b1;
  endtask

  task automatic test_sweep();
    logic [3:0] exp_tab [4];
    exp_tab[0] = 4'b0001; exp_tab[1] = 4'b0010; exp_tab[2] = 4'b0100; exp_tab[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sel = 2'(i); en = 1'b1; pol_high = 1'b1;
      #1;
      checks++;
      if (dec_c !== exp_tab[i]) begin errors++; $display("FAIL sweep_dec_c sel=%0d: got %b want %b", i, dec_c, exp_tab[i]); end
      @(posedge clk); #1;
      checks++;
      if (dec_q !== exp_tab[i] || vld_q !== 1'b1) begin
        errors++; $display("FAIL sweep_dec_q sel=%0d: got %b/%b want %b/1", i, dec_q, vld_q, exp_tab[i]);
      end
    end
  endtask

  task automatic test_active_low();
    @(negedge clk);
    pol_high = 1'b0; en = 1'b1; sel = 2'b10;
    #1;
    checks++;
    if (dec_c !== 4'b1011) begin errors++; $display("FAIL active_low_dec_c: got %b want 1011", dec_c); end
    @(posedge clk); #1;
    checks++;
    if (dec_q !== 4'b1011 || vld_q !== 1'b1) begin
      errors++; $display("FAIL active_low_dec_q: got %b/%b want 1011/1", dec_q, vld_q);
    end
  endtask

  task automatic test_disable();
    @(negedge clk);
    en = 1'b0; sel = 2'b11; pol_high = 1'b1;
    #1;
    checks++;
    if (dec_c !== 4'b0000) begin errors++; $display("FAIL disable_dec_c_pol1: got %b want 0000", dec_c); end
    pol_high = 1'b0;
    #1;
    checks++;
    if (dec_c !== 4'b1111) begin errors++; $display("FAIL disable_dec_c_pol0: got %b want 1111", dec_c); end
    @(posedge clk); #1;
    checks++;
    if (dec_q !== 4'b1111 || vld_q !== 1'b0) begin
      errors++; $display("FAIL disable_dec_q_pol0: got %b/%b want 1111/0", dec_q, vld_q);
    end
    pol_high = 1'b1;
    #1;
    checks++;
    if (dec_q !== 4'b0000) begin errors++; $display("FAIL disable_dec_q_pol1: got %b want 0000", dec_q); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sel = 2'b11; en = 1'b1; pol_high = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dec_q !== 4'b1000) begin errors++; $display("FAIL async_pre_dec_q: got %b want 1000", dec_q); end
    #1;
    RESET = 1'b0;
    #1;
    checks++;
    if (dec_q !== 4'b0000 || vld_q !== 1'b0) begin
      errors++; $display("FAIL async_reset_clear: got %b/%b want 0000/0", dec_q, vld_q);
    end
    sel = 2'b01;
    #1;
    RESET = 1'b1;
    #1;
    checks++;
    if (dec_q !== 4'b0000) begin errors++; $display("FAIL async_release_hold: got %b want 0000", dec_q); end
    @(posedge clk); #1;
    checks++;
    if (dec_q !== 4'b0010 || vld_q !== 1'b1) begin
      errors++; $display("FAIL async_first_capture: got %b/%b want 0010/1", dec_q, vld_q);
    end
  endtask

  task automatic test_polarity_flip();
    @(negedge clk);
    sel = 2'b01; en = 1'b1; pol_high = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dec_q !== 4'b0010) begin errors++; $display("FAIL polflip_pre: got %b want 0010", dec_q); end
    pol_high = 1'b0;
    #1;
    checks++;
    if (dec_q !== 4'b1101) begin errors++; $display("FAIL polflip_dec_q: got %b want 1101", dec_q); end
    checks++;
    if (dec_c !== 4'b1101) begin errors++; $display("FAIL polflip_dec_c: got %b want 1101", dec_c); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_active_low();
    test_disable();
    test_async_reset();
    test_polarity_flip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
